// File: rtl/square_sequential_if.sv
// -----------------------------------------------------------------------------
// square_sequential_if
//   Valid/ready stream bundle shared by the sequential squarer and its
//   neighbours. It has an operand stream (num) and a result stream (res).
//
//   Signals
//     num      N/2  operand from upstream
//     num_vld  1    upstream: num is valid
//     num_rdy  1    squarer can accept an operand
//     res      N    square of the accepted operand
//     res_vld  1    res is valid
//     res_rdy  1    downstream accepts res
//
//   Modports
//     master  environment side: drives num/num_vld and res_rdy
//     slave   squarer side: drives num_rdy, res and res_vld
// -----------------------------------------------------------------------------
interface square_sequential_if #(
  parameter int N = 16
);
  logic [N/2-1:0] num;
  logic           num_vld;
  logic           num_rdy;
  logic [N-1:0]   res;
  logic           res_vld;
  logic           res_rdy;

  modport master (
    output num, num_vld, res_rdy,
    input  num_rdy, res, res_vld
  );

  modport slave (
    input  num, num_vld, res_rdy,
    output num_rdy, res, res_vld
  );
endinterface

// File: rtl/square_sequential.sv
// -----------------------------------------------------------------------------
// square_sequential
//   Sequential integer squarer, res = num * num. It uses radix-2 shift-and-add
//   and processes one multiplier bit per clock. An operand is accepted on the
//   num stream. The result is produced N/2 clocks later on the res stream and
//   is held until the consumer takes it. Every output is registered, so no
//   input has a combinational path to an output.
//
//   Parameters
//     N        result width; the operand is N/2 bits. N must be even and >= 4.
//
//   Ports
//     clk      rising-edge clock
//     reset_n  synchronous, active-low reset
//     bus      square_sequential_if.slave stream bundle (num / res streams)
// -----------------------------------------------------------------------------
module square_sequential #(
  parameter int N = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  square_sequential_if.slave  bus
);

  if ((N % 2) != 0 || N < 4) begin : g_bad_n
    $error("square_sequential: N must be even and >= 4");
  end

  localparam int H     = N / 2;
  localparam int CNT_W = $clog2(H);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(H - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COMP = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_num_rdy;
  logic             r_res_vld;
  logic [N-1:0]     r_res;
  logic [N-1:0]     r_acc;
  logic [N-1:0]     r_mcand;
  logic [H-1:0]     r_mplr;
  logic [CNT_W-1:0] r_cnt;

  logic [N-1:0]     w_addend;
  logic [N-1:0]     w_sum;

  // Partial product for the current multiplier bit. The sum cannot overflow,
  // because (2^H-1)^2 < 2^N.
  assign w_addend = r_mplr[0] ? r_mcand : '0;
  assign w_sum    = r_acc + w_addend;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_num_rdy <= 1'b0;
      r_res_vld <= 1'b0;
      r_res     <= '0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplr    <= '0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          // num_rdy is low for the first cycle after reset, so num_vld in
          // that cycle is not taken.
          r_num_rdy <= 1'b1;
          if (bus.num_vld && r_num_rdy) begin
            r_mcand   <= {{H{1'b0}}, bus.num};
            r_mplr    <= bus.num;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_num_rdy <= 1'b0;
            r_state   <= COMP;
          end
        end
        COMP: begin
          r_acc   <= w_sum;
          r_mcand <= r_mcand << 1;
          r_mplr  <= r_mplr >> 1;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) begin
            r_res     <= w_sum;
            r_res_vld <= 1'b1;
            r_state   <= DONE;
          end
        end
        DONE: begin
          if (r_res_vld && bus.res_rdy) begin
            r_res_vld <= 1'b0;
            r_num_rdy <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_num_rdy <= 1'b0;
          r_res_vld <= 1'b0;
        end
      endcase
    end
  end

  assign bus.num_rdy = r_num_rdy;
  assign bus.res_vld = r_res_vld;
  assign bus.res     = r_res;

endmodule
